instr_issue_queue: RTL and testbench

Receiving end of the fetch-to-issue interface. Accepts instructions from the fetch stage with the `INSTRV`/`DEC_INSTR`/`ISSUE_BUSY` handshake and buffers them in a DEPTH-entry FIFO. Classifies each instruction by opcode and presents it to the execution stage through a valid/ready output register. It is the issue-side counterpart of the fetch modport and drives `ISSUE_BUSY` back to fetch.

---
 rtl/instr_issue_queue.sv | 154 +++++++++++++++
 tb/tb_instr_issue_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Issue-side receiver: buffers fetched instructions in a DEPTH-entry FIFO, classifies
// them on exit and presents them through a valid/ready output register.
// Optional build macro ISSUE_BYPASS_EN lets an accept load the empty output register directly.
module instr_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INSTRV,
  input  logic [31:0] DEC_INSTR,
  output logic        ISSUE_BUSY,
  input  logic        FLUSH,
  output logic        ISSUE_VALID,
  output logic [31:0] ISSUE_INSTR,
  output logic [2:0]  ISSUE_CLASS,
  input  logic        EXU_READY,
  output logic [15:0] ILL_CNT
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  localparam logic [2:0] CLS_ILLEGAL = 3'd0;
  localparam logic [2:0] CLS_ALU     = 3'd1;
  localparam logic [2:0] CLS_LOAD    = 3'd2;
  localparam logic [2:0] CLS_STORE   = 3'd3;
  localparam logic [2:0] CLS_BRANCH  = 3'd4;
  localparam logic [2:0] CLS_JUMP    = 3'd5;
  localparam logic [2:0] CLS_SYSTEM  = 3'd6;

  logic [31:0] r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic          r_issueValid;
  logic [31:0]   r_issueInstr;
  logic [2:0]    r_issueClass;
  logic [15:0]   r_illCnt;

  logic          w_accept;
  logic          w_handoff;
  logic          w_outFree;
  logic          w_fifoEmpty;
  logic          w_pop;
  logic          w_push;
  logic          w_bypass;
  logic          w_illHit;
  logic [31:0]   w_headInstr;
  logic [PW:0]   w_countNext;

  function automatic logic [2:0] decodeClass(input logic [6:0] opcode);
    logic [2:0] cls;
    cls = CLS_ILLEGAL;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: cls = CLS_ALU;
      7'b0000011:                                     cls = CLS_LOAD;
      7'b0100011:                                     cls = CLS_STORE;
      7'b1100011:                                     cls = CLS_BRANCH;
      7'b1101111, 7'b1100111:                         cls = CLS_JUMP;
      7'b1110011:                                     cls = CLS_SYSTEM;
      default:                                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Busy depends only on the registered count, so a same-edge pop never frees a slot.
  assign ISSUE_BUSY  = (r_count == FULL_COUNT);
  assign w_accept    = INSTRV & ~ISSUE_BUSY;
  assign w_handoff   = r_issueValid & EXU_READY;
  assign w_outFree   = ~r_issueValid | w_handoff;
  assign w_fifoEmpty = (r_count == '0);
  assign w_pop       = w_outFree & ~w_fifoEmpty;
  assign w_headInstr = r_mem[r_rdPtr];

`ifdef ISSUE_BYPASS_EN
  assign w_bypass = w_accept & w_outFree & w_fifoEmpty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push   = w_accept & ~w_bypass;
  assign w_illHit = w_handoff & (r_issueClass == CLS_ILLEGAL) & (r_illCnt != 16'hFFFF);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + (PW + 1)'(1);
    end else if (w_pop && !w_push) begin
      w_countNext = r_count - (PW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= DEC_INSTR;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (FLUSH) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= w_countNext;
    end
  end

  // Decode happens once, as the word enters the output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_issueValid <= 1'b0;
      r_issueInstr <= '0;
      r_issueClass <= CLS_ILLEGAL;
    end else if (FLUSH) begin
      r_issueValid <= 1'b0;
    end else if (w_pop) begin
      r_issueValid <= 1'b1;
      r_issueInstr <= w_headInstr;
      r_issueClass <= decodeClass(w_headInstr[6:0]);
    end else if (w_bypass) begin
      r_issueValid <= 1'b1;
      r_issueInstr <= DEC_INSTR;
      r_issueClass <= decodeClass(DEC_INSTR[6:0]);
    end else if (w_handoff) begin
      r_issueValid <= 1'b0;
    end
  end

  // Flush does not clear the illegal counter, and a flushing-edge handoff still counts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_illCnt <= '0;
    end else if (w_illHit) begin
      r_illCnt <= r_illCnt + 16'd1;
    end
  end

  assign ISSUE_VALID = r_issueValid;
  assign ISSUE_INSTR = r_issueInstr;
  assign ISSUE_CLASS = r_issueClass;
  assign ILL_CNT     = r_illCnt;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: accepted words are queued with their expected
// class and compared at each handoff; build with ISSUE_BYPASS_EN to check the bypass variant.
module tb_instr_issue_queue;

  localparam int DEPTH = 4;
`ifdef ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        INSTRV;
  logic [31:0] DEC_INSTR;
  logic        ISSUE_BUSY;
  logic        FLUSH;
  logic        ISSUE_VALID;
  logic [31:0] ISSUE_INSTR;
  logic [2:0]  ISSUE_CLASS;
  logic        EXU_READY;
  logic [15:0] ILL_CNT;

  logic [2:0]  stimClass;
  logic [34:0] scoreboard [$];
  logic [15:0] expIll;
  int          testCount = 0;
  int          failCount = 0;

  instr_issue_queue #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .INSTRV     (INSTRV),
    .DEC_INSTR  (DEC_INSTR),
    .ISSUE_BUSY (ISSUE_BUSY),
    .FLUSH      (FLUSH),
    .ISSUE_VALID(ISSUE_VALID),
    .ISSUE_INSTR(ISSUE_INSTR),
    .ISSUE_CLASS(ISSUE_CLASS),
    .EXU_READY  (EXU_READY),
    .ILL_CNT    (ILL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds the word until the queue accepts it, bounded so a stuck busy cannot hang the run.
  task automatic applyStimulus(input logic [31:0] word, input logic [2:0] cls);
    int waited;
    INSTRV    = 1'b1;
    DEC_INSTR = word;
    stimClass = cls;
    waited    = 0;
    while (ISSUE_BUSY && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) checkOutput("acceptTimeout", {63'd0, ISSUE_BUSY}, 64'd0);
    tick();
    INSTRV = 1'b0;
  endtask

  task automatic drainWait();
    for (int i = 0; i < 60 && (scoreboard.size() != 0 || ISSUE_VALID); i++) tick();
    checkOutput("drained", 64'(scoreboard.size()), 64'd0);
    checkOutput("drainedValid", {63'd0, ISSUE_VALID}, 64'd0);
  endtask

  // Monitor: sampled mid-cycle, so values reflect what the next rising edge will act on.
  always @(negedge CLK) begin
    logic [34:0] front;
    if (RST) begin
      scoreboard.delete();
    end else begin
      checkOutput("illCnt", {48'd0, ILL_CNT}, {48'd0, expIll});
      if (ISSUE_VALID && EXU_READY) begin
        checkOutput("issueHasEntry", {63'd0, scoreboard.size() != 0}, 64'd1);
        if (scoreboard.size() != 0) begin
          front = scoreboard.pop_front();
          checkOutput("issueInstr", {32'd0, ISSUE_INSTR}, {32'd0, front[31:0]});
          checkOutput("issueClass", {61'd0, ISSUE_CLASS}, {61'd0, front[34:32]});
          if (front[34:32] == 3'd0 && expIll != 16'hFFFF) expIll = expIll + 16'd1;
        end
      end
      if (FLUSH) scoreboard.delete();
      else if (INSTRV && !ISSUE_BUSY) scoreboard.push_back({stimClass, DEC_INSTR});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fillWords [6];
    logic [2:0]  fillClass [6];
    fillWords = '{32'h00000003, 32'h00000023, 32'h00000063, 32'h0000006F, 32'h00000073, 32'h00000013};
    fillClass = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};

    RST = 1'b1; INSTRV = 1'b0; DEC_INSTR = '0; FLUSH = 1'b0; EXU_READY = 1'b0;
    stimClass = '0; expIll = '0;
    tick();
    tick();
    checkOutput("rstBusy",  {63'd0, ISSUE_BUSY}, 64'd0);
    checkOutput("rstValid", {63'd0, ISSUE_VALID}, 64'd0);
    checkOutput("rstInstr", {32'd0, ISSUE_INSTR}, 64'd0);
    checkOutput("rstClass", {61'd0, ISSUE_CLASS}, 64'd0);
    checkOutput("rstIll",   {48'd0, ILL_CNT}, 64'd0);
    RST = 1'b0;

    // Single instruction latency: accept at edge 1, valid after edge LAT, gone after handoff.
    EXU_READY = 1'b1; INSTRV = 1'b1; DEC_INSTR = 32'h00500093; stimClass = 3'd1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      INSTRV = 1'b0;
      checkOutput($sformatf("latValidEdge%0d", k), {63'd0, ISSUE_VALID}, {63'd0, k == LAT});
    end
    drainWait();

    // Fill to full with backpressure, then drain in order.
    EXU_READY = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(fillWords[i], fillClass[i]);
    checkOutput("fullBusy", {63'd0, ISSUE_BUSY}, 64'd1);
    INSTRV = 1'b1; DEC_INSTR = fillWords[5]; stimClass = fillClass[5];
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("holdBusy",  {63'd0, ISSUE_BUSY}, 64'd1);
      checkOutput("holdValid", {63'd0, ISSUE_VALID}, 64'd1);
      checkOutput("holdInstr", {32'd0, ISSUE_INSTR}, 64'h00000003);
      checkOutput("holdClass", {61'd0, ISSUE_CLASS}, 64'd2);
    end
    EXU_READY = 1'b1;
    tick();
    checkOutput("busyDropAfterPop", {63'd0, ISSUE_BUSY}, 64'd0);
    tick();
    INSTRV = 1'b0;
    drainWait();

    // Illegal counting and saturation.
    for (int i = 0; i < 3; i++) applyStimulus(32'hFFFFFFFF, 3'd0);
    drainWait();
    checkOutput("illCnt3", {48'd0, ILL_CNT}, 64'd3);
    force dut.r_illCnt = 16'hFFFE;
    #1;
    release dut.r_illCnt;
    expIll = 16'hFFFE;
    checkOutput("illForced", {48'd0, ILL_CNT}, 64'hFFFE);
    for (int i = 0; i < 3; i++) applyStimulus(32'hFFFFFFFF, 3'd0);
    drainWait();
    checkOutput("illSat", {48'd0, ILL_CNT}, 64'hFFFF);

    // Flush colliding with an accept: the accepted word must never issue.
    EXU_READY = 1'b0;
    applyStimulus(32'h00000033, 3'd1);
    applyStimulus(32'h00000037, 3'd1);
    applyStimulus(32'h00000017, 3'd1);
    checkOutput("preFlushValid", {63'd0, ISSUE_VALID}, 64'd1);
    FLUSH = 1'b1; INSTRV = 1'b1; DEC_INSTR = 32'h00000013; stimClass = 3'd1;
    tick();
    FLUSH = 1'b0; INSTRV = 1'b0;
    checkOutput("flushValid", {63'd0, ISSUE_VALID}, 64'd0);
    checkOutput("flushBusy",  {63'd0, ISSUE_BUSY}, 64'd0);
    checkOutput("flushIll",   {48'd0, ILL_CNT}, 64'hFFFF);
    applyStimulus(32'h00000067, 3'd5);
    EXU_READY = 1'b1;
    drainWait();
    for (int i = 0; i < 4; i++) tick();

    // Asynchronous reset between edges with a full queue.
    EXU_READY = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(fillWords[i], fillClass[i]);
    checkOutput("preRstBusy", {63'd0, ISSUE_BUSY}, 64'd1);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("asyncBusy",  {63'd0, ISSUE_BUSY}, 64'd0);
    checkOutput("asyncValid", {63'd0, ISSUE_VALID}, 64'd0);
    checkOutput("asyncInstr", {32'd0, ISSUE_INSTR}, 64'd0);
    checkOutput("asyncClass", {61'd0, ISSUE_CLASS}, 64'd0);
    checkOutput("asyncIll",   {48'd0, ILL_CNT}, 64'd0);
    scoreboard.delete();
    expIll = '0;
    #1;
    RST = 1'b0;
    tick();

    applyStimulus(32'h00500093, 3'd1);
    EXU_READY = 1'b1;
    drainWait();
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
